// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding and default widths.
package count_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dec_prescaler.sv
// Reload-down counter that paces decrement requests: tick once every div+1 enabled clocks.
module dec_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] pre;

    assign tick = (pre == '0);

    // Datapath only; it is always reloaded in LOAD before its tick is used.
    always_ff @(posedge clock) begin
        if (load) begin
            pre <= div;
        end else if (en) begin
            pre <= tick ? div : pre - DIV_W'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Control sequencer for the loadable down-counter: accepts a count command, loads it,
// issues rate-limited decrements until the counter reports zero, and signals done/aborted.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_count,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt_in,
    output logic             cnt_latch,
    output logic             cnt_dec,
    input  logic             cnt_zero,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_r;
    logic             accept;
    logic             tick;
    logic             in_seq;

    assign accept = cmd_valid && cmd_ready;
    assign in_seq = (state == LOAD) || (state == RUN);

    dec_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clock (clock),
        .load  (state == LOAD),
        .div   (div_r),
        .en    (state == RUN),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: state_nxt = abort ? IDLE : RUN;
            RUN: begin
                // abort takes priority over a simultaneous zero
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        cnt_dec   = (state == RUN) && tick && !cnt_zero && !abort;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_in    <= '0;
            cnt_latch <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_in <= cmd_count;
            end
            cnt_latch <= accept;
            done      <= (state == RUN) && cnt_zero && !abort;
            aborted   <= in_seq && abort;
        end
    end

    // Interval is only consumed after a command has loaded it.
    always_ff @(posedge clock) begin
        if (accept) begin
            div_r <= cmd_div;
        end
    end

endmodule
